usb_cmd_decoder: RTL and testbench
==================================

# usb_cmd_decoder

Consumes the byte stream produced by the USB read stage and assembles framed gesture-command packets into four 8-bit drone control channels (throttle, yaw, pitch, roll). Validates framing and checksum, holds the last good command, and forces failsafe values when no good packet arrives within a timeout. Sits between the USB read stage and the channel/PWM generation logic.

## Interface
- `TIMEOUT_CYCLES`, default 250_000_000: clock cycles without a good packet before failsafe; counter width 28 bits.
- `SYNC_BYTE`, default 8'hA5: packet start marker.
- `clock`  in  1  system clock; the block has a single clock domain.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  8  byte from the USB read stage.
- `in_valid`  in  1  one-cycle strobe; `in_data` is valid this cycle.
- `throttle`, `yaw`, `pitch`, `roll`  out  8 each  current command channels.
- `cmd_valid`  out  1  one-cycle pulse when a good packet has been applied.
- `link_lost`  out  1  high while in failsafe.
- `err_count`  out  8  count of rejected packets, saturating at 255.

## Operation
- Packet format: SYNC, throttle, yaw, pitch, roll, CHK. CHK is the XOR of the four payload bytes; SYNC is excluded from CHK.
- FSM states:
  - HUNT: discard bytes until `in_valid` with `in_data == SYNC_BYTE` -> PAYLOAD, with idx=0 and running XOR=0.
  - PAYLOAD: each valid byte is stored into shadow register [idx] and XORed into the running value. idx increments from 0 to 3; at idx==3 the FSM moves to CHECK. A SYNC value inside the payload is treated as ordinary data.
  - CHECK: the next valid byte is compared with the running XOR.
    - On match: copy the shadow registers to the outputs, pulse `cmd_valid`, clear `link_lost`, reload the timeout counter.
    - On mismatch: `err_count` increments (saturating) and the outputs are unchanged.
    - Either way the FSM returns to HUNT.
- Cycles without `in_valid` never advance the FSM.
- Watchdog: a 28-bit counter increments every cycle and reloads to 0 on each good packet. When it reaches `TIMEOUT_CYCLES - 1`:
  - `link_lost` is set.
  - Outputs are forced to failsafe: throttle=8'h00, yaw=pitch=roll=8'h80.
  - The FSM is forced to HUNT, abandoning any partial packet.
  - The counter holds at that value; failsafe persists until the next good packet.
- A good packet completing on the same cycle as timeout expiry takes priority: its values are applied, the counter reloads, and `link_lost` is cleared.
- A `reset` mid-packet discards the partial packet.

## Timing
- Reset values:
  - throttle=8'h00, yaw=pitch=roll=8'h80.
  - cmd_valid=0, link_lost=1, err_count=0.
  - FSM=HUNT, watchdog counter=0, shadow registers=0.
- Latency: channels update and `cmd_valid` pulses on the clock edge that samples the CHK byte. The new values are visible the cycle after the CHK strobe, and `cmd_valid` is high for exactly one cycle.
- `in_valid` may be asserted on consecutive cycles; the block accepts one byte per cycle with no backpressure.
- `err_count` updates on the edge that samples a bad CHK.
- `link_lost` rises on the edge where the counter reaches `TIMEOUT_CYCLES - 1`.

## Configuration
- `USB_CMD_CHECKSUM_EN` defined: 6-byte packet with CHK verification, as described above.
- Not defined:
  - 5-byte packet (SYNC plus 4 payload bytes).
  - Commit happens on the edge sampling the roll byte; the CHECK state and XOR logic are absent.
  - `err_count` is tied to 0.

## Structure
- A shared package holds:
  - the FSM state enum (HUNT, PAYLOAD, CHECK);
  - the channel index constants (THR=0, YAW=1, PIT=2, ROL=3);
  - the failsafe constants FS_THROTTLE=8'h00 and FS_CENTER=8'h80;
  - the default SYNC value.
- One sub-module, `cmd_watchdog`:
  - ports: clock, reset, kick, expired;
  - parameter TIMEOUT_CYCLES;
  - holds the counter and the saturation logic.

## Test plan
- Reset with no input: after reset, throttle=00, yaw/pitch/roll=80, link_lost=1, cmd_valid never pulses.
- Good packet A5 40 10 20 30 (CHK 40^10^20^30 = 40): one-cycle cmd_valid; outputs 40/10/20/30; link_lost=0.
- Bad checksum A5 01 02 03 04 FF: outputs keep their previous values, err_count goes 0->1, and a following good packet is still accepted. A 256-bad-packet run leaves err_count=255.
- Noise then sync, with embedded sync: bytes 00 7F A5 A5 11 22 33 (CHK = A5^11^22^33 = A5) are accepted with throttle=A5, showing that SYNC inside the payload is treated as data.
- Timeout with TIMEOUT_CYCLES=100: a good packet followed by 100 idle cycles sets link_lost and failsafe outputs. A partial packet A5 01 sent before expiry is abandoned; a subsequent full good packet restores the outputs.
- Reset mid-packet: A5 01 02, then reset, then 03 04 CHK produces no cmd_valid; outputs stay at reset values.

Source files
------------

// File: rtl/usb_cmd_decoder_pkg.sv
// Shared definitions for the USB gesture-command decoder: FSM states, channel
// slot indices, failsafe values, default sync marker and watchdog width.
// No ports; imported by usb_cmd_decoder and cmd_watchdog.
package usb_cmd_decoder_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_e;

  // Slot of each channel in the packed shadow/output arrays (payload order).
  localparam int THR = 0;
  localparam int YAW = 1;
  localparam int PIT = 2;
  localparam int ROL = 3;

  localparam logic [7:0] FS_THROTTLE  = 8'h00;
  localparam logic [7:0] FS_CENTER    = 8'h80;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  localparam int WDOG_W = 28;

  // Failsafe image of all four channels; slot ROL is the most significant byte.
  localparam logic [3:0][7:0] FS_CHANNELS = {FS_CENTER, FS_CENTER, FS_CENTER, FS_THROTTLE};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/usb_cmd_decoder_watchdog.sv
// cmd_watchdog: link-loss timer; counts every cycle, reloads on kick, saturates.
// Latency: expired pulses on the edge where the counter reaches TIMEOUT_CYCLES-1.
// Backpressure: none. Ports: clock, reset (sync, active-high), kick, expired.
module cmd_watchdog
  import usb_cmd_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic kick,
  output logic expired
);

  localparam logic [WDOG_W-1:0] CNT_MAX = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (kick) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  // One-cycle event on the transition into the terminal count, so the parent
  // can abandon a partial packet once without blocking later reception.
  assign expired = !kick && (cnt_q != CNT_MAX) && (cnt_d == CNT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_cmd_decoder.sv
// usb_cmd_decoder: assembles framed packets from the USB byte stream into four
// 8-bit channels (throttle/yaw/pitch/roll) with failsafe on link loss.
// Latency: channels and cmd_valid update on the edge sampling the last byte.
// Backpressure: none; one byte per cycle accepted whenever in_valid is high.
// Ports: clock, reset (sync, active-high), in_data/in_valid in; throttle, yaw,
// pitch, roll, cmd_valid, link_lost, err_count out.
// Build option USB_CMD_CHECKSUM_EN: when defined, packets carry a trailing XOR
// checksum byte and bad packets are counted; otherwise packets are 5 bytes,
// commit on the roll byte, and err_count is tied to 0.
module usb_cmd_decoder
  import usb_cmd_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] throttle,
  output logic [7:0] yaw,
  output logic [7:0] pitch,
  output logic [7:0] roll,
  output logic       cmd_valid,
  output logic       link_lost,
  output logic [7:0] err_count
);

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][7:0] shadow_q, shadow_d;
  logic [3:0][7:0] chan_q, chan_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            link_lost_q, link_lost_d;
  logic            commit;
  logic            expired;
`ifdef USB_CMD_CHECKSUM_EN
  logic [7:0]      xor_q, xor_d;
  logic [7:0]      err_q, err_d;
`endif

  cmd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .kick   (commit),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    chan_d      = chan_q;
    cmd_valid_d = 1'b0;
    link_lost_d = link_lost_q;
    commit      = 1'b0;
`ifdef USB_CMD_CHECKSUM_EN
    xor_d       = xor_q;
    err_d       = err_q;
`endif

    case (state_q)
      HUNT: begin
        if (in_valid && (in_data == SYNC_BYTE)) begin
          state_d = PAYLOAD;
          idx_d   = 2'd0;
`ifdef USB_CMD_CHECKSUM_EN
          xor_d   = 8'h00;
`endif
        end
      end
      PAYLOAD: begin
        // A sync value here is plain payload data.
        if (in_valid) begin
          shadow_d[idx_q] = in_data;
          idx_d           = idx_q + 2'd1;
`ifdef USB_CMD_CHECKSUM_EN
          xor_d           = xor_q ^ in_data;
          if (idx_q == 2'd3) state_d = CHECK;
`else
          if (idx_q == 2'd3) begin
            state_d = HUNT;
            commit  = 1'b1;
          end
`endif
        end
      end
`ifdef USB_CMD_CHECKSUM_EN
      CHECK: begin
        if (in_valid) begin
          state_d = HUNT;
          if (in_data == xor_q) commit = 1'b1;
          else                  err_d  = sat_inc8(err_q);
        end
      end
`endif
      default: state_d = HUNT;
    endcase

    // A packet completing on the expiry edge wins; the watchdog also sees the
    // kick and does not report expiry in that case.
    if (commit) begin
      chan_d      = shadow_d;
      cmd_valid_d = 1'b1;
      link_lost_d = 1'b0;
    end else if (expired) begin
      chan_d      = FS_CHANNELS;
      link_lost_d = 1'b1;
      state_d     = HUNT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HUNT;
      idx_q       <= 2'd0;
      shadow_q    <= '0;
      chan_q      <= FS_CHANNELS;
      cmd_valid_q <= 1'b0;
      link_lost_q <= 1'b1;
`ifdef USB_CMD_CHECKSUM_EN
      xor_q       <= 8'h00;
      err_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      chan_q      <= chan_d;
      cmd_valid_q <= cmd_valid_d;
      link_lost_q <= link_lost_d;
`ifdef USB_CMD_CHECKSUM_EN
      xor_q       <= xor_d;
      err_q       <= err_d;
`endif
    end
  end

  assign throttle  = chan_q[THR];
  assign yaw       = chan_q[YAW];
  assign pitch     = chan_q[PIT];
  assign roll      = chan_q[ROL];
  assign cmd_valid = cmd_valid_q;
  assign link_lost = link_lost_q;
`ifdef USB_CMD_CHECKSUM_EN
  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_usb_cmd_decoder.sv
// Self-checking bench for usb_cmd_decoder with a short watchdog timeout.
// Expected packets are queued when sent; a monitor compares on each cmd_valid.
module tb_usb_cmd_decoder;

  localparam int unsigned TMO = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] throttle, yaw, pitch, roll, err_count;
  logic       cmd_valid, link_lost;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic        prev_cv = 1'b0;

  usb_cmd_decoder #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .throttle (throttle),
    .yaw      (yaw),
    .pitch    (pitch),
    .roll     (roll),
    .cmd_valid(cmd_valid),
    .link_lost(link_lost),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every cmd_valid must match the oldest queued packet.
  always @(negedge clock) begin
    if (!reset && cmd_valid) begin
      check("cmd_valid_single_cycle", {31'd0, prev_cv}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_cmd_valid", {throttle, yaw, pitch, roll}, 32'hxxxxxxxx);
      end else begin
        check("packet_channels", {throttle, yaw, pitch, roll}, exp_q.pop_front());
      end
    end
    prev_cv = cmd_valid;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
      in_data  = 8'h00;
    end
  endtask

  // Sends SYNC + payload (+ checksum when enabled). chk_ok=0 corrupts the checksum.
  task automatic send_pkt(input logic [7:0] t, y, p, r, input bit good);
    send_byte(8'hA5);
    send_byte(t);
    send_byte(y);
    send_byte(p);
    send_byte(r);
`ifdef USB_CMD_CHECKSUM_EN
    send_byte(good ? (t ^ y ^ p ^ r) : ~(t ^ y ^ p ^ r));
`endif
    if (good) exp_q.push_back({t, y, p, r});
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset    = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(3);
    reset = 1'b0;
    check("rst_throttle", {24'd0, throttle}, 32'h00);
    check("rst_yaw", {24'd0, yaw}, 32'h80);
    check("rst_pitch", {24'd0, pitch}, 32'h80);
    check("rst_roll", {24'd0, roll}, 32'h80);
    check("rst_link_lost", {31'd0, link_lost}, 32'd1);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    idle(10);

    // Basic good packet
    send_pkt(8'h40, 8'h10, 8'h20, 8'h30, 1'b1);
    idle(2);
    check("good_channels", {throttle, yaw, pitch, roll}, 32'h40102030);
    check("good_link_lost", {31'd0, link_lost}, 32'd0);

    // Bad checksum, then recovery
`ifdef USB_CMD_CHECKSUM_EN
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'hFF);
    idle(2);
    check("bad_keeps_channels", {throttle, yaw, pitch, roll}, 32'h40102030);
    check("bad_err_count", {24'd0, err_count}, 32'd1);
    send_pkt(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b1);
    idle(2);
    check("after_bad_good", {throttle, yaw, pitch, roll}, 32'h0A0B0C0D);
    // Enough bad packets to saturate even if a few are cut by watchdog expiry.
    for (int i = 0; i < 300; i++) send_pkt(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    idle(2);
    check("err_saturated", {24'd0, err_count}, 32'd255);
`else
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'hFF);
    exp_q.push_back(32'h01020304);
    idle(2);
    check("nochk_commit_on_roll", {throttle, yaw, pitch, roll}, 32'h01020304);
    check("nochk_err_tied", {24'd0, err_count}, 32'd0);
`endif

    // Noise, then a packet whose first payload byte equals SYNC
    send_byte(8'h00);
    send_byte(8'h7F);
    send_pkt(8'hA5, 8'h11, 8'h22, 8'h33, 1'b1);
    idle(2);
    check("embedded_sync", {throttle, yaw, pitch, roll}, 32'hA5112233);

    // Exact timeout boundary: expiry on the 99th edge after the commit edge
    send_pkt(8'h55, 8'h66, 8'h77, 8'h88, 1'b1);
    idle(TMO - 1);
    check("tmo_before_link", {31'd0, link_lost}, 32'd0);
    check("tmo_before_chan", {throttle, yaw, pitch, roll}, 32'h55667788);
    idle(1);
    check("tmo_link_lost", {31'd0, link_lost}, 32'd1);
    check("tmo_failsafe", {throttle, yaw, pitch, roll}, 32'h00808080);

    // Partial packet abandoned by expiry
    send_pkt(8'h12, 8'h34, 8'h56, 8'h78, 1'b1);
    idle(2);
    check("pre_partial_link", {31'd0, link_lost}, 32'd0);
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(TMO + 10);
    check("partial_link_lost", {31'd0, link_lost}, 32'd1);
    check("partial_failsafe", {throttle, yaw, pitch, roll}, 32'h00808080);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
`ifdef USB_CMD_CHECKSUM_EN
    send_byte(8'h04);
`endif
    idle(3);
    check("partial_dropped", {throttle, yaw, pitch, roll}, 32'h00808080);
    send_pkt(8'h9A, 8'hBC, 8'hDE, 8'hF0, 1'b1);
    idle(2);
    check("restore_chan", {throttle, yaw, pitch, roll}, 32'h9ABCDEF0);
    check("restore_link", {31'd0, link_lost}, 32'd0);

    // Reset mid-packet
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    reset_dut();
    send_byte(8'h03); send_byte(8'h04);
`ifdef USB_CMD_CHECKSUM_EN
    send_byte(8'h04);
`endif
    idle(3);
    check("midrst_chan", {throttle, yaw, pitch, roll}, 32'h00808080);
    check("midrst_link", {31'd0, link_lost}, 32'd1);
    check("midrst_err", {24'd0, err_count}, 32'd0);

    idle(5);
    check("all_packets_seen", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, tests %0d", tests);
    $fatal(1);
  end

endmodule
